// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants, stage-count helper and flag bundle for addsub_pipe
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flag_t;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// rtl/addsub_if.sv - operation/result handshake bundle for addsub_pipe
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/addsub_stage.sv
// rtl/addsub_stage.sv - one CHUNK-bit slice adder with carry/valid/payload registers (ADDSUB_SATURATE_EN clamps in last stage)
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CHUNK   = 4,
    parameter int IDX     = 0,
    parameter bit IS_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output flag_t            out_flags
);
    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   slice_res;
    logic [WIDTH-1:0] sum_new;
    logic             ovf;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    flag_t            flags_q, flags_d;

    always_comb begin
        slice_res = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, in_carry};
        sum_new              = in_sum;
        sum_new[LO +: CHUNK] = slice_res[CHUNK-1:0];
        // in_b is already the effective operand (inverted for subtract)
        ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_new[WIDTH-1] != in_a[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
        if (IS_LAST && ovf) begin
            sum_new = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif

        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        flags_d = flags_q;
        if (advance) begin
            valid_d = in_valid;
            a_d     = in_a;
            b_d     = in_b;
            sum_d   = sum_new;
            carry_d = slice_res[CHUNK];
            flags_d = '0;
            if (IS_LAST) begin
                flags_d.cout     = slice_res[CHUNK];
                flags_d.overflow = ovf;
                flags_d.zero     = (sum_new == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_flags = flags_q;

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined WIDTH-bit add/sub, one CHUNK slice per stage, valid/ready backpressure (ADDSUB_SATURATE_EN optional)
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst,
    addsub_if.slave  bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic             advance;
    logic             valid_c [STAGES+1];
    logic [WIDTH-1:0] a_c     [STAGES+1];
    logic [WIDTH-1:0] b_c     [STAGES+1];
    logic [WIDTH-1:0] sum_c   [STAGES+1];
    logic             carry_c [STAGES+1];
    flag_t            flags_out;

    // Whole pipe moves in lockstep; a held result freezes every stage
    assign advance      = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = advance;

    assign valid_c[0] = bus.in_valid;
    assign a_c[0]     = bus.a;
    assign b_c[0]     = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    assign sum_c[0]   = '0;
    assign carry_c[0] = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        flag_t stage_flags;

        addsub_stage #(
            .WIDTH   (WIDTH),
            .CHUNK   (CHUNK),
            .IDX     (k),
            .IS_LAST (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (valid_c[k]),
            .in_a      (a_c[k]),
            .in_b      (b_c[k]),
            .in_sum    (sum_c[k]),
            .in_carry  (carry_c[k]),
            .out_valid (valid_c[k+1]),
            .out_a     (a_c[k+1]),
            .out_b     (b_c[k+1]),
            .out_sum   (sum_c[k+1]),
            .out_carry (carry_c[k+1]),
            .out_flags (stage_flags)
        );

        if (k == STAGES - 1) begin : g_last
            logic unused_tail;
            assign flags_out   = stage_flags;
            assign unused_tail = ^{a_c[k+1], b_c[k+1], carry_c[k+1]};
        end else begin : g_mid
            logic unused_flags;
            assign unused_flags = ^stage_flags;
        end
    end

    assign bus.out_valid = valid_c[STAGES];
    assign bus.sum       = sum_c[STAGES];
    assign bus.cout      = flags_out.cout;
    assign bus.overflow  = flags_out.overflow;
    assign bus.zero      = flags_out.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe (WIDTH=8, CHUNK=4)
module tb_addsub_pipe;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q [$];

    addsub_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        logic [7:0] be;
        logic [8:0] r;
        exp_t       e;
        be     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + {8'b0, (sub ? 1'b1 : cin)};
        e.sum  = r[7:0];
        e.cout = r[8];
        e.ovf  = (a[7] == be[7]) && (r[7] != a[7]);
`ifdef ADDSUB_SATURATE_EN
        if (e.ovf) e.sum = a[7] ? 8'h80 : 8'h7F;
`endif
        e.zero = (e.sum == 8'h00);
        return e;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                        input exp_t e);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send_accept", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && sb_q.size() != 0; w++) @(posedge clk);
        #1;
        check_eq("drain", sb_q.size(), 32'd0);
    endtask

    // Result side: every transfer pops the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", sb_q.size(), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("sum",      {24'b0, bus.sum},      {24'b0, e.sum});
                check_eq("cout",     {31'b0, bus.cout},     {31'b0, e.cout});
                check_eq("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
                check_eq("zero",     {31'b0, bus.zero},     {31'b0, e.zero});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_sum",       {24'b0, bus.sum},       32'd0);
        check_eq("rst_flags",     {29'b0, bus.cout, bus.overflow, bus.zero}, 32'd0);
        check_eq("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        @(posedge clk); #1;

        // Directed cases from the plan
        send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1));
`ifdef ADDSUB_SATURATE_EN
        send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b1, 1'b0));
`else
        send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0));
`endif
        send(8'h05, 8'h07, 1'b1, 1'b0, mk(8'hFE, 1'b0, 1'b0, 1'b0));
        send(8'h05, 8'h07, 1'b1, 1'b1, mk(8'hFE, 1'b0, 1'b0, 1'b0));
`ifdef ADDSUB_SATURATE_EN
        send(8'h80, 8'h01, 1'b1, 1'b0, mk(8'h80, 1'b1, 1'b1, 1'b0));
`else
        send(8'h80, 8'h01, 1'b1, 1'b0, mk(8'h7F, 1'b1, 1'b1, 1'b0));
`endif
        send(8'h0F, 8'h01, 1'b0, 1'b1, mk(8'h11, 1'b0, 1'b0, 1'b0));
        send(8'h07, 8'h07, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1));
        idle();
        drain();

        // Stall: first result sits at the output for three cycles
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'h10, 8'h01, 1'b0, 1'b0, mk(8'h11, 1'b0, 1'b0, 1'b0));
                send(8'h20, 8'h02, 1'b0, 1'b0, mk(8'h22, 1'b0, 1'b0, 1'b0));
                send(8'h30, 8'h03, 1'b0, 1'b0, mk(8'h33, 1'b0, 1'b0, 1'b0));
                bus.in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 0;
                for (int w = 0; w < 20 && !seen; w++) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                end
                check_eq("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                for (int s = 0; s < 3; s++) begin
                    if (s != 0) @(negedge clk);
                    check_eq("stall_in_ready", {31'b0, bus.in_ready},  32'd0);
                    check_eq("stall_hold_sum", {24'b0, bus.sum},       32'h11);
                    check_eq("stall_hold_vld", {31'b0, bus.out_valid}, 32'd1);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight, in_valid high during reset
        send(8'h01, 8'h01, 1'b0, 1'b0, mk(8'h02, 1'b0, 1'b0, 1'b0));
        send(8'h04, 8'h04, 1'b0, 1'b0, mk(8'h08, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        bus.a = 8'h55; bus.b = 8'h11; bus.sub = 1'b0; bus.cin = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst2_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst2_sum",       {24'b0, bus.sum},       32'd0);
        check_eq("rst2_flags",     {29'b0, bus.cout, bus.overflow, bus.zero}, 32'd0);
        check_eq("rst2_in_ready",  {31'b0, bus.in_ready},  32'd1);
        @(negedge clk);
        check_eq("rst_dominates",  {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        send(8'h02, 8'h03, 1'b0, 1'b0, mk(8'h05, 1'b0, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("latency_early", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check_eq("latency_due",   {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Random stream with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] ra, rb;
                    logic       rs, rc;
                    if ($urandom_range(0, 3) == 0) idle();
                    ra = 8'($urandom); rb = 8'($urandom);
                    rs = 1'($urandom); rc = 1'($urandom);
                    send(ra, rb, rs, rc, model(ra, rb, rs, rc));
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
